// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared word-addressed memory port.
// Combinational grant in the request cycle; fixed-latency read data routed back by an owner tag pipe.
module mem_port_arbiter #(
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned M0_PRIORITY  = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic [31:0] rdata
);

    localparam int unsigned CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    logic             sel_m1;
    logic             accept;
    logic             rd_accept;
    owner_e           last_gnt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_owner;

    // Requester selection; M0 is the default when nobody asks
    always_comb begin
        sel_m1 = 1'b0;
        if (M0_PRIORITY != 0) begin
            if (STARVE_LIMIT != 0) begin
                sel_m1 = m1_req & (~m0_req | (starve_cnt == CNT_W'(STARVE_LIMIT)));
            end else begin
                sel_m1 = m1_req & ~m0_req;
            end
        end else begin
            sel_m1 = m1_req & (~m0_req | (last_gnt == OWN_M0));
        end
    end

    // Command forwarding and grants, all forced quiet while reset is held
    always_comb begin
        mem_req   = rst_n & (m0_req | m1_req);
        mem_we    = sel_m1 ? m1_we    : m0_we;
        mem_addr  = sel_m1 ? m1_addr  : m0_addr;
        mem_size  = sel_m1 ? m1_size  : m0_size;
        mem_wdata = sel_m1 ? m1_wdata : m0_wdata;
        m0_gnt    = rst_n & ~sel_m1 & m0_req & mem_ready;
        m1_gnt    = rst_n &  sel_m1 & m1_req & mem_ready;
        accept    = mem_req & mem_ready;
        rd_accept = accept & ~mem_we;
    end

    // Starvation counter only advances on cycles where memory could have taken M1
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (m1_gnt) begin
            starve_cnt_nxt = '0;
        end else if (m1_req & m0_req & mem_ready & (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            last_gnt   <= OWN_M1;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            if (m0_gnt) begin
                last_gnt <= OWN_M0;
            end else if (m1_gnt) begin
                last_gnt <= OWN_M1;
            end
        end
    end

    // Read-return tag pipe: shifts every cycle, stage 0 captures the accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
            tag_valid[0] <= rd_accept;
            tag_owner[0] <= sel_m1;
        end
    end

    always_comb begin
        m0_rvalid = rst_n & tag_valid[RD_LAT-1] & ~tag_owner[RD_LAT-1];
        m1_rvalid = rst_n & tag_valid[RD_LAT-1] &  tag_owner[RD_LAT-1];
        rdata     = mem_rdata;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single word-addressed memory port between two requesters: M0 (the core datapath's fetch/load/store port) and M1 (debug/DMA loader). It arbitrates each cycle, forwards the winning command to memory, and routes fixed-latency read data back to the requester that issued it. In the M0-priority mode a starvation counter bounds how long M1 can be locked out.

Parameters:
RD_LAT, 1, memory read latency in cycles from accepted request to mem_rdata valid; legal 1..4
M0_PRIORITY, 1, 1 = fixed priority to M0 with starvation guard; 0 = round-robin
STARVE_LIMIT, 8, consecutive denied M1 cycles before M1 is forced to win; 0 disables the guard (pure M0 priority); width of counter = $clog2(STARVE_LIMIT+1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  M0 command valid; must stay asserted with stable fields until m0_gnt
m0_we  in  1  M0 write enable (0 = read)
m0_addr  in  32  M0 byte address
m0_size  in  2  M0 access size (mem_addr_t encoding: B/H/W)
m0_wdata  in  32  M0 write data
m0_gnt  out  1  M0 command accepted this cycle
m0_rvalid  out  1  mem_rdata belongs to M0 this cycle
m1_req, m1_we, m1_addr, m1_size, m1_wdata, m1_gnt, m1_rvalid  same as M0 for requester 1
mem_req  out  1  command valid to memory
mem_we  out  1  forwarded write enable
mem_addr  out  32  forwarded address
mem_size  out  2  forwarded size
mem_wdata  out  32  forwarded write data
mem_ready  in  1  memory accepts a command this cycle
mem_rdata  in  32  read data, valid RD_LAT cycles after an accepted read
rdata  out  32  mem_rdata passed through unregistered to both requesters

Behaviour:
- Grant is combinational in the request cycle: mem_req = m0_req | m1_req; command fields muxed from the selected requester; mx_gnt = selected & mx_req & mem_ready.
- No requester: mem_req=0, fields driven from M0 (don't-care to memory), no grants.
- Selection, M0_PRIORITY=1: M1 wins iff m1_req & (!m0_req | (STARVE_LIMIT!=0 & starve_cnt==STARVE_LIMIT)); else M0.
- Selection, M0_PRIORITY=0: both requesting -> requester not in last_gnt wins; single requester always wins. last_gnt updates only on an actual grant.
- starve_cnt: on m1_gnt -> 0; else if m1_req & m0_req & mem_ready & !m1_gnt -> increment, saturating at STARVE_LIMIT; otherwise hold. Cycles with mem_ready=0 do not count.
- Read return: shift register of RD_LAT entries {valid, owner}. Every cycle shifts by one; stage 0 loaded with {mem_req & mem_ready & !mem_we, selected}. mx_rvalid = tail.valid & tail.owner==x. Shift is unconditional; mem_ready only gates new acceptance. Writes never produce rvalid.
- Back-to-back reads from alternating requesters are legal each cycle; returns appear in issue order, one per cycle.
- Writes complete on grant; no write response.
- Reset (async, rst_n=0): all tag valids=0, starve_cnt=0, last_gnt=M1 (so M0 wins first RR tie). While rst_n=0: mem_req=0, m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0 regardless of inputs. Reads in flight at reset assertion are dropped; no rvalid after release for them.
- Reset deassertion takes effect on the next rising edge; arbitration valid in that cycle.
- Requester dropping mx_req before grant is a protocol violation; behaviour undefined, assertion in bench.

Test Plan:
- Reset then M0 read addr 0x100, RD_LAT=1, mem_ready=1 -> m0_gnt same cycle, mem_addr=0x100, mem_we=0; next cycle m0_rvalid=1, rdata=mem_rdata, m1_rvalid=0.
- M0_PRIORITY=1, STARVE_LIMIT=8, M0 and M1 requesting continuously -> M0 granted 8 cycles, M1 granted on 9th, counter back to 0, M0 granted next 8.
- M0_PRIORITY=0, both requesting continuously -> grants alternate M0,M1,M0,...; first grant after reset is M0.
- RD_LAT=3, reads M0@0x10, M1@0x20, M0@0x30 on consecutive cycles -> rvalid M0,M1,M0 on cycles 3,4,5 after first grant; write M1 interleaved produces no rvalid.
- mem_ready=0 for 5 cycles with both requesting -> no grants, starve_cnt unchanged, in-flight read still returns on schedule.
- rst_n asserted one cycle after accepted read, RD_LAT=2 -> outputs zero immediately (async), no m0_rvalid after release; next request granted to M0.
